// File: rtl/fifo_mc_sync_pkg.sv
// Shared datapath constants for the multi-lane FIFO: sample width, antenna count
// and used-subcarrier count, used as parameter defaults by fifo_mc_sync.
package fifo_mc_sync_pkg;

   localparam int FIXED_POINT_WIDTH = 16;
   localparam int NUM_ANT           = 2;
   localparam int FFT_USED_SC       = 220;

endpackage

// File: rtl/fifo_mc_sync_ram.sv
// sdp_ram_mc: simple dual-port storage, one write port and a registered read port
// that holds its last value when not enabled. No reset on the array or read register.
module sdp_ram_mc #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 220,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Read-before-write: a read and write to the same slot return the old word,
   // which is what the full-with-read case needs.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem[raddr];
      end
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_mc_sync.sv
// Multi-lane synchronous FIFO for the MIMO-OFDM datapath, any depth >= 2.
// Optional sticky overflow/underflow flags are built when FIFO_MC_ERR_FLAGS_EN is defined.
module fifo_mc_sync
   import fifo_mc_sync_pkg::*;
#(
   parameter int DATA_W = FIXED_POINT_WIDTH,
   parameter int CH     = NUM_ANT,
   parameter int DEPTH  = FFT_USED_SC,
   parameter int AF_LVL = DEPTH - 4,
   parameter int AE_LVL = 4,
   parameter int CW     = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               w_en,
   input  logic [CH*DATA_W-1:0] din,
   input  logic               r_en,
   output logic [CH*DATA_W-1:0] dout,
   output logic               r_valid,
   output logic [CW-1:0]      count,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
`ifdef FIFO_MC_ERR_FLAGS_EN
   output logic               almost_empty,
   output logic               overflow,
   output logic               underflow
`else
   output logic               almost_empty
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_LVL);
   localparam logic [CW-1:0] AE_C     = CW'(AE_LVL);

   logic [PW-1:0] wPtr_q, wPtr_d, rPtr_q, rPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rValid_q, rValid_d;
   logic          doutLoaded_q;
   logic          rdOk, wrOk, ramWe, ramRe;
   logic [CH*DATA_W-1:0] ramRdata;

   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;

   assign rdOk  = r_en && !empty;
   assign wrOk  = w_en && (!full || rdOk);
   assign ramWe = wrOk && !flush;
   assign ramRe = rdOk && !flush;

   // Pointers wrap by explicit compare so non-power-of-two depths work.
   always_comb begin
      wPtr_d   = wPtr_q;
      rPtr_d   = rPtr_q;
      count_d  = count_q;
      rValid_d = 1'b0;
      if (flush) begin
         wPtr_d  = '0;
         rPtr_d  = '0;
         count_d = '0;
      end else begin
         rValid_d = rdOk;
         if (rdOk) begin
            rPtr_d = (rPtr_q == LAST_PTR) ? '0 : rPtr_q + PW'(1);
         end
         if (wrOk) begin
            wPtr_d = (wPtr_q == LAST_PTR) ? '0 : wPtr_q + PW'(1);
         end
         case ({wrOk, rdOk})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wPtr_q       <= '0;
         rPtr_q       <= '0;
         count_q      <= '0;
         rValid_q     <= 1'b0;
         doutLoaded_q <= 1'b0;
      end else begin
         wPtr_q   <= wPtr_d;
         rPtr_q   <= rPtr_d;
         count_q  <= count_d;
         rValid_q <= rValid_d;
         if (ramRe) begin
            doutLoaded_q <= 1'b1;
         end
      end
   end

   sdp_ram_mc #(
      .WIDTH (CH * DATA_W),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) uRam (
      .clk   (clk),
      .we    (ramWe),
      .waddr (wPtr_q),
      .wdata (din),
      .re    (ramRe),
      .raddr (rPtr_q),
      .rdata (ramRdata)
   );

   // The RAM read register has no reset, so dout reads as zero until the first read.
   assign dout    = doutLoaded_q ? ramRdata : '0;
   assign r_valid = rValid_q;

`ifdef FIFO_MC_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   // A read on empty alongside a write is the legitimate empty-collision case.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flush) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (w_en && !wrOk) begin
            overflow_q <= 1'b1;
         end
         if (r_en && empty && !w_en) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_mc_sync.sv
// Self-checking bench for fifo_mc_sync (DEPTH 220, two 16-bit lanes) using a
// table of short vectors, a queue reference model and a read-data scoreboard.
module tb_fifo_mc_sync;

   localparam int DATA_W = 16;
   localparam int CH     = 2;
   localparam int DEPTH  = 220;
   localparam int W      = CH * DATA_W;
   localparam int CW     = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic [W-1:0]  din = '0;
   logic [W-1:0]  dout;
   logic          r_valid;
   logic [CW-1:0] count;
   logic          full, empty, almost_full, almost_empty;
`ifdef FIFO_MC_ERR_FLAGS_EN
   logic          overflow, underflow;
`endif

   int nVec  = 0;
   int nFail = 0;

   logic [W-1:0] mq[$];
   logic [W-1:0] sbq[$];
   bit           expRv = 1'b0;
   bit           mOvf  = 1'b0;
   bit           mUdf  = 1'b0;

   fifo_mc_sync #(
      .DATA_W (DATA_W),
      .CH     (CH),
      .DEPTH  (DEPTH),
      .AF_LVL (216),
      .AE_LVL (4),
      .CW     (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .w_en         (w_en),
      .din          (din),
      .r_en         (r_en),
      .dout         (dout),
      .r_valid      (r_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
`ifdef FIFO_MC_ERR_FLAGS_EN
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
`else
      .almost_empty (almost_empty)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          w;
      bit          r;
      bit          f;
      logic [31:0] din;
      int          expCount;
      bit          expRv;
      logic [31:0] expDout;
   } vec_t;

   vec_t vecs[9];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clearModel();
      mq.delete();
      sbq.delete();
      expRv = 1'b0;
      mOvf  = 1'b0;
      mUdf  = 1'b0;
   endtask

   // Compare every visible output against the reference queue model.
   task automatic checkOutput();
      int sz;
      sz = mq.size();
      checkVal("count", 32'(count), 32'(sz));
      checkVal("r_valid", 32'(r_valid), 32'(expRv));
      checkVal("empty", 32'(empty), 32'(sz == 0));
      checkVal("full", 32'(full), 32'(sz == DEPTH));
      checkVal("almost_full", 32'(almost_full), 32'(sz >= 216));
      checkVal("almost_empty", 32'(almost_empty), 32'(sz <= 4));
      if (r_valid) begin
         if (sbq.size() == 0) begin
            nVec++;
            nFail++;
            $display("[TB] FAIL dout: got 0x%0h, expected no read data", dout);
         end else begin
            checkVal("dout", dout, sbq.pop_front());
         end
      end
`ifdef FIFO_MC_ERR_FLAGS_EN
      checkVal("overflow", 32'(overflow), 32'(mOvf));
      checkVal("underflow", 32'(underflow), 32'(mUdf));
`endif
   endtask

   // Drive one cycle from a falling edge, update the model, check at the next falling edge.
   task automatic applyStimulus(input bit w, input bit r, input bit f, input logic [W-1:0] d);
      bit rd, wr;
      w_en  = w;
      r_en  = r;
      flush = f;
      din   = d;
      rd = r && (mq.size() != 0);
      wr = w && ((mq.size() < DEPTH) || rd);
      if (f) begin
         mq.delete();
         expRv = 1'b0;
         mOvf  = 1'b0;
         mUdf  = 1'b0;
      end else begin
         if (w && !wr) mOvf = 1'b1;
         if (r && (mq.size() == 0) && !w) mUdf = 1'b1;
         if (rd) sbq.push_back(mq.pop_front());
         if (wr) mq.push_back(d);
         expRv = rd;
      end
      @(posedge clk);
      @(negedge clk);
      w_en  = 1'b0;
      r_en  = 1'b0;
      flush = 1'b0;
      checkOutput();
   endtask

   task automatic checkResetValues(input string tag);
      checkVal({tag, " dout"}, dout, 32'h0);
      checkVal({tag, " r_valid"}, 32'(r_valid), 32'h0);
      checkVal({tag, " count"}, 32'(count), 32'h0);
      checkVal({tag, " full"}, 32'(full), 32'h0);
      checkVal({tag, " empty"}, 32'(empty), 32'h1);
      checkVal({tag, " almost_full"}, 32'(almost_full), 32'h0);
      checkVal({tag, " almost_empty"}, 32'(almost_empty), 32'h1);
`ifdef FIFO_MC_ERR_FLAGS_EN
      checkVal({tag, " overflow"}, 32'(overflow), 32'h0);
      checkVal({tag, " underflow"}, 32'(underflow), 32'h0);
`endif
   endtask

   initial begin
      int rvCount;

      vecs[0] = '{1, 1, 0, 32'h0000_00A5, 1, 0, 32'h0000_0000};
      vecs[1] = '{0, 1, 0, 32'h0,         0, 1, 32'h0000_00A5};
      vecs[2] = '{0, 1, 0, 32'h0,         0, 0, 32'h0000_00A5};
      vecs[3] = '{1, 0, 0, 32'h0011_0011, 1, 0, 32'h0000_00A5};
      vecs[4] = '{1, 0, 0, 32'h0022_0022, 2, 0, 32'h0000_00A5};
      vecs[5] = '{1, 1, 0, 32'h0033_0033, 2, 1, 32'h0011_0011};
      vecs[6] = '{1, 0, 1, 32'h0044_0044, 0, 0, 32'h0011_0011};
      vecs[7] = '{1, 0, 0, 32'h0055_0055, 1, 0, 32'h0011_0011};
      vecs[8] = '{0, 1, 0, 32'h0,         0, 1, 32'h0055_0055};

      rst = 1'b1;
      clearModel();
      @(negedge clk);
      @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].din);
         checkVal($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].expCount));
         checkVal($sformatf("vec%0d r_valid", i), 32'(r_valid), 32'(vecs[i].expRv));
         checkVal($sformatf("vec%0d dout", i), dout, vecs[i].expDout);
`ifdef FIFO_MC_ERR_FLAGS_EN
         if (i == 1) checkVal("underflow after empty collision", 32'(underflow), 32'h0);
         if (i == 2) checkVal("underflow after empty read", 32'(underflow), 32'h1);
         if (i == 6) checkVal("underflow after flush", 32'(underflow), 32'h0);
`endif
      end

      // Fill with lane data equal to the index, watching the threshold crossings.
      for (int k = 0; k < DEPTH; k++) begin
         applyStimulus(1, 0, 0, {16'(k), 16'(k)});
         if (k == 3)   checkVal("almost_empty at 4", 32'(almost_empty), 32'h1);
         if (k == 4)   checkVal("almost_empty at 5", 32'(almost_empty), 32'h0);
         if (k == 214) checkVal("almost_full at 215", 32'(almost_full), 32'h0);
         if (k == 215) checkVal("almost_full at 216", 32'(almost_full), 32'h1);
      end
      checkVal("full after 220", 32'(full), 32'h1);

      rvCount = 0;
      for (int k = 0; k < DEPTH + 2; k++) begin
         applyStimulus(0, 1, 0, '0);
         if (r_valid) rvCount++;
         if (k < DEPTH) checkVal("drain order", dout, {16'(k), 16'(k)});
      end
      checkVal("r_valid cycles", 32'(rvCount), 32'd220);
      checkVal("empty after drain", 32'(empty), 32'h1);
      checkVal("almost_empty after drain", 32'(almost_empty), 32'h1);

      // Full collisions: lone write dropped, write with read accepted.
      for (int k = 0; k < DEPTH; k++) applyStimulus(1, 0, 0, 32'h0100_0000 + k);
      applyStimulus(1, 0, 0, 32'hDEAD_BEEF);
      checkVal("count after dropped write", 32'(count), 32'd220);
`ifdef FIFO_MC_ERR_FLAGS_EN
      checkVal("overflow after dropped write", 32'(overflow), 32'h1);
`endif
      applyStimulus(1, 1, 0, 32'hCAFE_F00D);
      checkVal("count after full collision", 32'(count), 32'd220);
      checkVal("dout after full collision", dout, 32'h0100_0000);

      // Drain to 100 then flush with a simultaneous write.
      for (int k = 0; k < 120; k++) applyStimulus(0, 1, 0, '0);
      checkVal("count before flush", 32'(count), 32'd100);
      applyStimulus(1, 0, 1, 32'h1234_5678);
      checkVal("count after flush", 32'(count), 32'h0);
`ifdef FIFO_MC_ERR_FLAGS_EN
      checkVal("overflow after flush", 32'(overflow), 32'h0);
`endif

      // Prefill 3 and stream 500 words: level stays constant across two pointer wraps.
      for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 32'h2000 + k);
      for (int k = 0; k < 500; k++) begin
         applyStimulus(1, 1, 0, 32'h3000 + k);
         checkVal("stream count", 32'(count), 32'd3);
         if (k < 3) checkVal("stream prefill order", dout, 32'h2000 + k);
         else       checkVal("stream order", dout, 32'h3000 + k - 3);
      end

      // Asynchronous reset in the middle of a cycle, no clock edge in between.
      #2;
      rst = 1'b1;
      #1;
      checkResetValues("async reset");
      clearModel();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1, 0, 0, 32'h0000_0077);
      checkVal("first write after reset", 32'(count), 32'd1);
      applyStimulus(0, 1, 0, '0);
      checkVal("read after reset", dout, 32'h0000_0077);
      checkVal("scoreboard drained", 32'(sbq.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
